// File: rtl/uart_instr_loader.sv
// UART 8N1 program loader: a one-byte word-count header followed by big-endian
// 32-bit instructions, written to instruction memory at sequential addresses.
module uart_instr_loader #(
  parameter int F_CLK       = 50_000_000,
  parameter int BAUD        = 921_600,
  parameter int CLK_PER_BIT = F_CLK / BAUD,
  parameter int INSTR_WIDTH = 32,
  parameter int INSTR_DEPTH = 256,
  parameter int PC_WIDTH    = $clog2(INSTR_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   load_clr,
  output logic                   wr_en,
  output logic [PC_WIDTH-1:0]    wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   load_done,
  output logic                   frame_err,
  output logic [PC_WIDTH:0]      words_loaded
);

  localparam int TW = $clog2(CLK_PER_BIT + 1);
  // Word counter must hold 256 even when the memory is shallower.
  localparam int CW = (PC_WIDTH + 1 > 9) ? PC_WIDTH + 1 : 9;
  localparam logic [TW-1:0] FULL_T  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_T  = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(INSTR_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {L_HEADER, L_LOAD, L_DONE} ld_state_e;

  logic rx_meta_q, rx_sync_q;

  rx_state_e        r_state_q, r_state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, byte_err;

  ld_state_e        l_state_q, l_state_d;
  logic [CW-1:0]    n_q, n_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;
  logic             pend_q, pend_d;
  logic             wr_en_q, wr_en_d;
  logic [PC_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          r_state_d = R_START;
          timer_d   = HALF_T;
        end
      end
      R_START: begin
        if (timer_q == '0) begin
          if (!rx_sync_q) begin
            r_state_d = R_DATA;
            timer_d   = FULL_T;
            bit_cnt_d = '0;
          end else begin
            r_state_d = R_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      R_DATA: begin
        if (timer_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          timer_d    = FULL_T;
          if (bit_cnt_q == 3'd7) r_state_d = R_STOP;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      R_STOP: begin
        if (timer_q == '0) begin
          byte_valid = rx_sync_q;
          byte_err   = !rx_sync_q;
          r_state_d  = R_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (load_clr) r_state_d = R_IDLE;
  end

  always_comb begin
    l_state_d = l_state_q;
    n_d       = n_q;
    count_d   = count_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pend_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ferr_d    = ferr_q | byte_err;
    // Bookkeeping for the word whose write strobe is on the bus this cycle.
    if (pend_q) begin
      count_d = count_q + 1'b1;
      if (count_q + 1'b1 < DEPTH_C) wr_addr_d = wr_addr_q + 1'b1;
      if (count_q + 1'b1 == n_q) begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        l_state_d = L_DONE;
      end
    end
    case (l_state_q)
      L_HEADER: begin
        if (byte_valid) begin
          n_d       = (rx_shift_q == 8'd0) ? CW'(256) : CW'(rx_shift_q);
          busy_d    = 1'b1;
          wr_addr_d = '0;
          count_d   = '0;
          idx_d     = '0;
          l_state_d = L_LOAD;
        end
      end
      L_LOAD: begin
        if (byte_valid) begin
          shift_d = {shift_q[INSTR_WIDTH-9:0], rx_shift_q};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            pend_d    = 1'b1;
            wr_en_d   = (count_q < DEPTH_C);
            wr_data_d = {shift_q[INSTR_WIDTH-9:0], rx_shift_q};
          end
        end else if (byte_err) begin
          busy_d    = 1'b0;
          idx_d     = '0;
          l_state_d = L_HEADER;
        end
      end
      default: ;
    endcase
    if (load_clr) begin
      l_state_d = L_HEADER;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      count_d   = '0;
      wr_addr_d = '0;
      idx_d     = '0;
      pend_d    = 1'b0;
      wr_en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      l_state_q  <= L_HEADER;
      n_q        <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      pend_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      l_state_q  <= l_state_d;
      n_q        <= n_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign load_done    = done_q;
  assign frame_err    = ferr_q;
  assign words_loaded = count_q[PC_WIDTH:0];

endmodule

// File: tb/tb_uart_instr_loader.sv
// Scoreboarded bench for uart_instr_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each wr_en pulse (address, data, timing).
module tb_uart_instr_loader;
  // Short bit time keeps the 256-word load affordable; 2-cycle glitch < half bit.
  localparam int C   = 6;
  localparam int PCW = 8;
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, load_clr = 1'b0;
  logic wr_en, busy, load_done, frame_err;
  logic [PCW-1:0] wr_addr;
  logic [31:0]    wr_data;
  logic [PCW:0]   words_loaded;

  int total = 0, bad = 0, cyc = 0;
  logic prev_wr = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          when;
  } wr_t;
  wr_t sb[$];

  uart_instr_loader #(.CLK_PER_BIT(C), .INSTR_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .load_clr(load_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .load_done(load_done), .frame_err(frame_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      prev_wr = 1'b0;
    end else begin
      if (wr_en) begin
        chk("wr_not_b2b", 32'(prev_wr), 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h expected no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
          chk("wr_latency", 32'(cyc), 32'(e.when));
        end
      end
      prev_wr = wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic wr,
                           input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    rx = 1'b0;
    if (wr) sb.push_back('{a, d, cyc + LAT});
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (C) @(posedge clk);
    end
    #1 rx = stop;
    repeat (C) @(posedge clk);
    #1;
    if (!stop) begin
      rx = 1'b1;
      repeat (2 * C) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [7:0] a);
    send_byte(w[31:24], 1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(w[23:16], 1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(w[15:8],  1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(w[7:0],   1'b1, 1'b1, a, w);
  endtask

  task automatic hdr(input logic [7:0] n);
    send_byte(n, 1'b1, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    @(posedge clk); #1 load_clr = 1'b1;
    @(posedge clk); #1 load_clr = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d,
                            input logic f, input int w);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(load_done), 32'(d));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(f));
    chk({tag, "_words"}, 32'(words_loaded), 32'(w));
  endtask

  initial begin
    logic [7:0] bi;
    #23;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    settle();

    // single word
    hdr(8'h01);
    settle();
    chk_status("single_mid", 1'b1, 1'b0, 1'b0, 0);
    send_word(32'hDEADBEEF, 8'd0);
    settle();
    chk_status("single_end", 1'b0, 1'b1, 1'b0, 1);

    // multi-word, then bytes after done must be ignored
    clr();
    chk_status("clr1", 1'b0, 1'b0, 1'b0, 0);
    chk("clr1_wr_addr", 32'(wr_addr), 32'd0);
    hdr(8'h03);
    send_word(32'h11223344, 8'd0);
    send_word(32'hA5A55A5A, 8'd1);
    send_word(32'h00FF00FF, 8'd2);
    settle();
    chk_status("multi_end", 1'b0, 1'b1, 1'b0, 3);
    send_byte(8'h99, 1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(8'h42, 1'b1, 1'b0, 8'd0, 32'd0);
    settle();
    chk_status("after_done", 1'b0, 1'b1, 1'b0, 3);

    // glitch then framing error mid-word
    clr();
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk); #1 rx = 1'b1;
    repeat (3 * C) @(posedge clk); #1;
    chk_status("glitch", 1'b0, 1'b0, 1'b0, 0);
    hdr(8'h02);
    send_word(32'hCAFEF00D, 8'd0);
    send_byte(8'h77, 1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(8'h88, 1'b0, 1'b0, 8'd0, 32'd0);
    settle();
    chk_status("ferr", 1'b0, 1'b0, 1'b1, 1);
    hdr(8'h01);
    settle();
    chk_status("ferr_rehdr", 1'b1, 1'b0, 1'b1, 0);
    send_word(32'h01020304, 8'd0);
    settle();
    chk_status("ferr_reload", 1'b0, 1'b1, 1'b1, 1);

    // load_clr mid-load
    clr();
    hdr(8'h02);
    send_byte(8'hAA, 1'b1, 1'b0, 8'd0, 32'd0);
    send_byte(8'hBB, 1'b1, 1'b0, 8'd0, 32'd0);
    settle();
    clr();
    chk_status("clr_mid", 1'b0, 1'b0, 1'b0, 0);
    chk("clr_mid_wr_addr", 32'(wr_addr), 32'd0);
    hdr(8'h01);
    send_word(32'h13579BDF, 8'd0);
    settle();
    chk_status("clr_reload", 1'b0, 1'b1, 1'b0, 1);

    // async reset mid-byte
    clr();
    hdr(8'h02);
    settle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (C + 3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk_status("arst", 1'b0, 1'b0, 1'b0, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    hdr(8'h01);
    send_word(32'h0BADC0DE, 8'd0);
    settle();
    chk_status("post_rst", 1'b0, 1'b1, 1'b0, 1);

    // header 0 means 256 words
    clr();
    hdr(8'h00);
    for (int i = 0; i < 256; i++) begin
      bi = 8'(i);
      if (i == 255) begin
        settle();
        chk_status("w255", 1'b1, 1'b0, 1'b0, 255);
      end
      send_word({bi, bi ^ 8'h5A, ~bi, 8'h3C}, bi);
    end
    settle();
    chk_status("full_end", 1'b0, 1'b1, 1'b0, 256);
    chk("full_wr_addr", 32'(wr_addr), 32'd255);
    clr();
    chk("full_clr_wr_addr", 32'(wr_addr), 32'd0);

    settle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
